// File: rtl/gpio_in_conditioner.sv
// Switch input conditioner: per-bit 2-flop synchronizer, counter debouncer,
// sticky rise/fall event flags with write-1-to-clear, and a small read mux.
module gpio_in_conditioner #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_COUNTS = 500_000,
  parameter logic [31:0] STAT_ADDR       = 32'h1001_0024,
  parameter logic [31:0] EVT_ADDR        = 32'h1001_0028
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic [31:0]      Adr_in,
  input  logic             MemWrite_in,
  input  logic [31:0]      Data_in,
  output logic [31:0]      Data_out,
  output logic [WIDTH-1:0] sw_clean,
  output logic             event_pending
);

  localparam int unsigned   CW      = (DEBOUNCE_COUNTS > 1) ? $clog2(DEBOUNCE_COUNTS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_COUNTS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  logic             evt_wr_s;
  logic [WIDTH-1:0] clr_rise_s;
  logic [WIDTH-1:0] clr_fall_s;
  logic             unused_data_s;

  // Synchronizer shift and per-bit debounce counters.
  always_comb begin
    sync1_d   = sw_raw;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = {CW{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Sticky edge flags; a set in the same cycle as its clear takes priority.
  always_comb begin
    evt_wr_s = MemWrite_in && (Adr_in == EVT_ADDR);
    if (evt_wr_s) begin
      clr_rise_s = Data_in[WIDTH-1:0];
      clr_fall_s = Data_in[8 +: WIDTH];
    end else begin
      clr_rise_s = {WIDTH{1'b0}};
      clr_fall_s = {WIDTH{1'b0}};
    end
    rise_d = (rise_q & ~clr_rise_s) | (deb_q & ~deb_dly_q);
    fall_d = (fall_q & ~clr_fall_s) | (~deb_q & deb_dly_q);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= {WIDTH{1'b0}};
      sync2_q   <= {WIDTH{1'b0}};
      deb_q     <= {WIDTH{1'b0}};
      deb_dly_q <= {WIDTH{1'b0}};
      rise_q    <= {WIDTH{1'b0}};
      fall_q    <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Read mux; each field is zero-extended to a byte.
  always_comb begin
    if (Adr_in == STAT_ADDR) begin
      Data_out = {8'h00, 8'(fall_q), 8'(rise_q), 8'(deb_q)};
    end else if (Adr_in == EVT_ADDR) begin
      Data_out = {16'h0000, 8'(fall_q), 8'(rise_q)};
    end else begin
      Data_out = 32'h0000_0000;
    end
  end

  assign sw_clean      = deb_q;
  assign event_pending = |{rise_q, fall_q};
  assign unused_data_s = ^Data_in;

endmodule
